instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode/control stage.
//  - Owns the PC and issues single-outstanding requests to instruction memory.
//  - Presents the fetched instruction in an IF/ID register; if_id_opcode feeds the control unit.
//  - Honours decode stalls through a one-entry skid buffer.
//  - Honours branch/jump redirects by killing in-flight and buffered fetches.
// PARAMETERS
//  ADDR_W    32            PC / imem address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  NOP_INSTR 32'h0000_0000 bubble instruction (sll $0,$0,0)
// PORTS
//  clk            in   1       clock, rising edge
//  arst           in   1       asynchronous reset, active-high
//  imem_req       out  1       fetch request, high for exactly one cycle per fetch
//  imem_addr      out  ADDR_W  fetch address, valid while imem_req=1 (= pc, bits[1:0]=0)
//  imem_rvalid    in   1       response strobe, >=1 cycle after imem_req
//  imem_rdata     in   32      instruction word, valid with imem_rvalid
//  stall_id       in   1       decode cannot accept; hold the IF/ID register
//  redirect_valid in   1       taken branch/jump, one-cycle pulse
//  redirect_pc    in   ADDR_W  redirect target; bits[1:0] are forced to 0
//  if_id_valid    out  1       IF/ID holds a real instruction
//  if_id_instr    out  32      IF/ID instruction; NOP_INSTR when invalid
//  if_id_pc_plus4 out  ADDR_W  fetch address of if_id_instr + 4
//  if_id_opcode   out  6       if_id_instr[31:26], combinational, to control unit
// BEHAVIOUR
//  Reset (async, arst=1): state=FETCH, pc=RESET_PC, kill=0, skid empty.
//   Outputs under reset: if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, imem_req=0.
//  FSM states: FETCH, WAIT, FULL.
//   FETCH: imem_req=1, imem_addr=pc; next state WAIT.
//   WAIT: no request. On imem_rvalid:
//    - kill=1: discard the word, kill<=0, next state FETCH.
//    - accept (= !if_id_valid | !stall_id): IF/ID <= {1, rdata, pc+4}; pc<=pc+4; next state FETCH.
//    - else: skid <= {rdata, pc+4}; pc<=pc+4; next state FULL.
//   FULL: when !stall_id: IF/ID <= skid; next state FETCH.
//  Throughput: best case 1 instr / 2 cycles (1-cycle memory). Latency: req -> IF/ID valid = mem latency + 1 edge.
//  IF/ID with no new word and !stall_id: valid<=0, instr<=NOP_INSTR (bubble). With stall_id: hold all fields.
//  Redirect has priority over stall, response and accept, in every state:
//   - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
//   - IF/ID flushed (valid=0, NOP) even if stall_id=1; skid dropped.
//   - FETCH: the request to the old pc still goes out; next WAIT with kill=1.
//   - WAIT with no rvalid: kill<=1, stay WAIT.
//   - WAIT with rvalid in the same cycle: word discarded, next FETCH, kill stays 0.
//   - FULL: next FETCH.
//  imem_rvalid outside WAIT is ignored (protocol violation; bench flags it).
//  PC arithmetic is modulo 2^ADDR_W; pc+4 wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
//  Reset asserted mid-fetch: everything returns to reset values immediately; a late rvalid after release lands in FETCH and is ignored.
// STRUCTURE
//  Shared package (mips_pkg): opcode constants (ALU_R, ADDI, BEQ, J, LW, SW), NOP_INSTR, RESET_PC, state encoding.
//  One sub-module: if_id_reg, the IF/ID register with load / hold / flush controls and NOP insertion.
//  FSM, PC and skid buffer live in the top module.
// TESTING
//  T1 reset: arst=1 mid-run -> if_id_valid=0, if_id_instr=0; first imem_addr=0x0 in the cycle after release.
//  T2 streaming: 1-cycle mem returns 0x8C08_0004 (lw) then 0x2109_0001 (addi).
//   -> if_id_opcode 0x23 then 0x08; if_id_pc_plus4 0x4 then 0x8; imem_addr 0x0, 0x4, 0x8.
//  T3 stall: stall_id=1 for 3 cycles while a response arrives -> IF/ID holds the old word, skid captures the new one.
//   After release the new word appears next edge; no instruction lost or duplicated.
//  T4 redirect in WAIT: redirect_pc=0x0000_0103 while a 3-cycle fetch is in flight -> stale word discarded.
//   Next imem_addr=0x0000_0100; IF/ID flushed to NOP.
//  T5 simultaneous: redirect + rvalid + stall_id in the same cycle.
//   -> word discarded, IF/ID flushed despite stall, FETCH of target next cycle.
//  T6 wrap: RESET_PC=0xFFFF_FFFC -> if_id_pc_plus4=0x0, next imem_addr=0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, reset/bubble constants and
// the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_ALU_R = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response on one side,
// decode-stage IF/ID, stall and redirect on the other.
interface instr_fetch_unit_if #(parameter int ADDR_W = 32);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              stall_id;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc_plus4;
  logic [5:0]        if_id_opcode;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_opcode,
    input  imem_rvalid, imem_rdata, stall_id, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_opcode,
    output imem_rvalid, imem_rdata, stall_id, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; an idle,
// un-stalled cycle inserts a bubble.
module if_id_reg #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc4_o
);

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (!hold_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, one-entry skid
// buffer for decode stalls, and redirect kill of in-flight fetches.
//   state | meaning
//   FETCH | request to pc is on the bus this cycle
//   WAIT  | request outstanding; kill_q marks a fetch to discard
//   FULL  | skid buffer holds a word waiting for decode to accept
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0]       NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               arst,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redir_pc;
  logic              accept;
  logic              req;
  logic              ifid_load, ifid_flush;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc4;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign redir_pc = bus.redirect_pc & ~ADDR_W'(3);
  assign accept   = !bus.if_id_valid || !bus.stall_id;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_WAIT;
        if (bus.redirect_valid) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (bus.imem_rvalid) begin
            state_d = ST_FETCH;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            pc_d = pc_plus4;
            if (accept) begin
              state_d = ST_FETCH;
            end else begin
              state_d      = ST_FULL;
              skid_instr_d = bus.imem_rdata;
              skid_pc4_d   = pc_plus4;
            end
          end
        end
      end
      ST_FULL: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = ST_FETCH;
        end else if (!bus.stall_id) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Request is masked while reset is held so nothing leaves before release.
  always_comb begin
    req        = (state_q == ST_FETCH) && !arst;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = skid_instr_q;
    ifid_pc4   = skid_pc4_q;
    if (bus.redirect_valid) begin
      ifid_flush = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (bus.imem_rvalid && !kill_q && accept) begin
            ifid_load  = 1'b1;
            ifid_instr = bus.imem_rdata;
            ifid_pc4   = pc_plus4;
          end
        end
        ST_FULL: ifid_load = !bus.stall_id;
        default: ifid_load = 1'b0;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .arst    (arst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .hold_i  (bus.stall_id),
    .instr_i (ifid_instr),
    .pc4_i   (ifid_pc4),
    .valid_o (bus.if_id_valid),
    .instr_o (bus.if_id_instr),
    .pc4_o   (bus.if_id_pc_plus4)
  );

  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc_q;
  assign bus.if_id_opcode = opcode_of(bus.if_id_instr);

endmodule
